// File: rtl/imem_fetch_responder.sv
// +----------------------------------------------------------------------------+
// | imem_fetch_responder                                                       |
// | Instruction RAM with a fixed-latency read pipeline, credit flow control    |
// | and an in-order response FIFO.                                             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module imem_fetch_responder #(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] address_imem,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic [ADDR_WIDTH-1:0] resp_addr,
  input  logic                  flush,
  input  logic                  load_en,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  busy
);

  localparam int c_ptr_w  = $clog2(FIFO_DEPTH);
  localparam int c_cred_w = $clog2(FIFO_DEPTH + 1);
  localparam logic [c_cred_w-1:0] c_credit_max = c_cred_w'(FIFO_DEPTH);
  localparam logic [c_cred_w-1:0] c_credit_one = c_cred_w'(1);
  localparam logic [c_ptr_w:0]    c_ptr_one    = (c_ptr_w + 1)'(1);

  logic [DATA_WIDTH-1:0] r_ram [2**ADDR_WIDTH];

  logic [READ_LATENCY-1:0] r_pipe_valid;
  logic [ADDR_WIDTH-1:0]   r_pipe_addr [READ_LATENCY];
  logic [DATA_WIDTH-1:0]   r_pipe_data [READ_LATENCY];

  logic [DATA_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] r_fifo_addr [FIFO_DEPTH];
  logic [c_ptr_w:0]      r_wptr;
  logic [c_ptr_w:0]      r_rptr;

  logic [c_cred_w-1:0] r_credit;
  logic [c_cred_w-1:0] w_credit_next;

  logic w_accept;
  logic w_pop;
  logic w_push;

  assign req_ready = reset & ~flush & ~load_en & (r_credit < c_credit_max);
  assign w_accept  = req_valid & req_ready;
  assign w_pop     = resp_valid & resp_ready & ~flush;
  assign w_push    = r_pipe_valid[READ_LATENCY-1];

  assign resp_valid = (r_wptr != r_rptr);
  assign resp_data  = resp_valid ? r_fifo_data[r_rptr[c_ptr_w-1:0]] : '0;
  assign resp_addr  = resp_valid ? r_fifo_addr[r_rptr[c_ptr_w-1:0]] : '0;
  assign busy       = (r_credit != '0);

  // RAM contents survive reset; only the write itself is held off during reset.
  always_ff @(posedge clock) begin
    if (reset && load_en) begin
      r_ram[load_addr] <= load_data;
    end
  end

  // Datapath stages carry no reset; r_pipe_valid qualifies them.
  always_ff @(posedge clock) begin
    r_pipe_addr[0] <= address_imem;
    r_pipe_data[0] <= r_ram[address_imem];
    for (int i = 1; i < READ_LATENCY; i++) begin
      r_pipe_addr[i] <= r_pipe_addr[i-1];
      r_pipe_data[i] <= r_pipe_data[i-1];
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_fifo_data[r_wptr[c_ptr_w-1:0]] <= r_pipe_data[READ_LATENCY-1];
      r_fifo_addr[r_wptr[c_ptr_w-1:0]] <= r_pipe_addr[READ_LATENCY-1];
    end
  end

  always_comb begin
    w_credit_next = r_credit;
    if (w_accept && !w_pop) begin
      w_credit_next = r_credit + c_credit_one;
    end else if (!w_accept && w_pop) begin
      w_credit_next = r_credit - c_credit_one;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_pipe_valid <= '0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_credit     <= '0;
    end else if (flush) begin
      r_pipe_valid <= '0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_credit     <= '0;
    end else begin
      r_pipe_valid[0] <= w_accept;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_pipe_valid[i] <= r_pipe_valid[i-1];
      end
      if (w_push) begin
        r_wptr <= r_wptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_ptr_one;
      end
      r_credit <= w_credit_next;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_imem_fetch_responder.sv
// +----------------------------------------------------------------------------+
// | tb_imem_fetch_responder                                                    |
// | Self-checking bench: vector table, directed sequences, random vs. model.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_imem_fetch_responder;

  localparam int c_lat   = 2;
  localparam int c_depth = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [11:0] address_imem;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [11:0] resp_addr;
  logic        flush;
  logic        load_en;
  logic [11:0] load_addr;
  logic [31:0] load_data;
  logic        busy;

  imem_fetch_responder #(
    .ADDR_WIDTH(12), .DATA_WIDTH(32), .READ_LATENCY(c_lat), .FIFO_DEPTH(c_depth)
  ) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .address_imem(address_imem), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_addr(resp_addr), .flush(flush), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .busy(busy)
  );

  always #5 clock = ~clock;

  // Reference model: outstanding requests in accept order, each with the word
  // it must return and the edge after which it may be presented.
  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
    int          due;
  } pend_t;

  pend_t       q[$];
  logic [31:0] mram [4096];
  int          edge_n = 0;

  int checks   = 0;
  int failures = 0;

  logic        obs_ready, obs_valid, obs_busy;
  logic [31:0] obs_data;
  logic [11:0] obs_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic step(input logic rst_i, input logic fl, input logic ld,
                      input logic [11:0] la, input logic [31:0] ldd,
                      input logic rv, input logic [11:0] a, input logic rr);
    logic exp_ready, exp_valid, acc, pop;
    @(negedge clock);
    reset = rst_i; flush = fl; load_en = ld; load_addr = la; load_data = ldd;
    req_valid = rv; address_imem = a; resp_ready = rr;
    #1;
    exp_ready = rst_i & ~fl & ~ld & (q.size() < c_depth);
    exp_valid = (q.size() > 0) && (q[0].due <= edge_n);
    chk("req_ready", {31'b0, req_ready}, {31'b0, exp_ready});
    chk("resp_valid", {31'b0, resp_valid}, {31'b0, exp_valid});
    chk("busy", {31'b0, busy}, {31'b0, (q.size() > 0)});
    if (exp_valid) begin
      chk("resp_data", resp_data, q[0].data);
      chk("resp_addr", {20'b0, resp_addr}, {20'b0, q[0].addr});
    end
    obs_ready = req_ready; obs_valid = resp_valid; obs_busy = busy;
    obs_data = resp_data; obs_addr = resp_addr;
    acc = rv & exp_ready;
    pop = exp_valid & rr & ~fl;
    @(posedge clock);
    edge_n++;
    if (!rst_i || fl) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back('{addr: a, data: mram[a], due: edge_n + c_lat});
    end
    if (rst_i && ld) mram[la] = ldd;
  endtask

  task automatic idle(input logic rr);
    step(1'b1, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 12'h0, rr);
  endtask

  task automatic req(input logic [11:0] a, input logic rr);
    step(1'b1, 1'b0, 1'b0, 12'h0, 32'h0, 1'b1, a, rr);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 30) begin
      idle(1'b1);
      n++;
    end
    chk("drain_timeout", {31'b0, (q.size() == 0)}, 32'd1);
  endtask

  typedef struct {
    logic        rst, fl, ld;
    logic [11:0] la;
    logic [31:0] ldd;
    logic        rv;
    logic [11:0] a;
    logic        rr;
    logic        exp_ready, exp_valid;
    logic [31:0] exp_data;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int first_valid, n_valid, n_acc;
    logic saw_valid;

    tbl[0]  = '{1, 0, 0, 12'h0, 32'h0,    1, 12'd1, 1, 1, 0, 32'h0};
    tbl[1]  = '{1, 0, 0, 12'h0, 32'h0,    1, 12'd2, 1, 1, 0, 32'h0};
    tbl[2]  = '{1, 0, 0, 12'h0, 32'h0,    0, 12'd0, 1, 1, 0, 32'h0};
    tbl[3]  = '{1, 0, 0, 12'h0, 32'h0,    0, 12'd0, 1, 1, 1, 32'hA1};
    tbl[4]  = '{1, 0, 0, 12'h0, 32'h0,    0, 12'd0, 0, 1, 1, 32'hA2};
    tbl[5]  = '{1, 0, 1, 12'd3, 32'hBEEF, 1, 12'd3, 0, 0, 1, 32'hA2};
    tbl[6]  = '{1, 0, 0, 12'h0, 32'h0,    1, 12'd3, 1, 1, 1, 32'hA2};
    tbl[7]  = '{1, 0, 0, 12'h0, 32'h0,    0, 12'd0, 1, 1, 0, 32'h0};
    tbl[8]  = '{1, 0, 0, 12'h0, 32'h0,    0, 12'd0, 1, 1, 0, 32'h0};
    tbl[9]  = '{1, 0, 0, 12'h0, 32'h0,    0, 12'd0, 1, 1, 1, 32'hBEEF};
    tbl[10] = '{1, 1, 0, 12'h0, 32'h0,    1, 12'd0, 1, 0, 0, 32'h0};
    tbl[11] = '{1, 0, 0, 12'h0, 32'h0,    0, 12'd0, 1, 1, 0, 32'h0};

    reset = 1'b0; flush = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
    req_valid = 1'b0; address_imem = '0; resp_ready = 1'b0;
    repeat (3) @(posedge clock);

    // Reset state
    step(1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 12'h0, 1'b0);
    chk("rst_ready", {31'b0, obs_ready}, 32'd0);
    chk("rst_data", obs_data, 32'd0);
    chk("rst_addr", {20'b0, obs_addr}, 32'd0);

    // Program load
    for (int i = 0; i < 8; i++)
      step(1'b1, 1'b0, 1'b1, 12'(i), 32'hA0 + 32'(i), 1'b0, 12'h0, 1'b0);
    for (int i = 8; i < 16; i++)
      step(1'b1, 1'b0, 1'b1, 12'(i), $urandom, 1'b0, 12'h0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 12'hFFF, 32'h1234_5678, 1'b0, 12'h0, 1'b0);

    // Back-to-back stream 0..7
    first_valid = -1; n_valid = 0;
    for (int i = 0; i < 14; i++) begin
      if (i < 8) req(12'(i), 1'b1); else idle(1'b1);
      if (obs_valid) begin
        if (first_valid < 0) first_valid = i;
        n_valid++;
      end
    end
    chk("b2b_first_latency", 32'(first_valid), 32'(c_lat + 1));
    chk("b2b_resp_count", 32'(n_valid), 32'd8);

    // Vector table
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].rst, tbl[i].fl, tbl[i].ld, tbl[i].la, tbl[i].ldd,
           tbl[i].rv, tbl[i].a, tbl[i].rr);
      chk($sformatf("tbl%0d_ready", i), {31'b0, obs_ready}, {31'b0, tbl[i].exp_ready});
      chk($sformatf("tbl%0d_valid", i), {31'b0, obs_valid}, {31'b0, tbl[i].exp_valid});
      if (tbl[i].exp_valid) chk($sformatf("tbl%0d_data", i), obs_data, tbl[i].exp_data);
    end

    // Backpressure: exactly FIFO_DEPTH accepts with resp_ready low
    n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      req(12'(i), 1'b0);
      if (obs_ready) n_acc++;
    end
    chk("stall_accepts", 32'(n_acc), 32'(c_depth));
    drain();
    req(12'd7, 1'b1);
    chk("stall_resume", {31'b0, obs_ready}, 32'd1);
    drain();

    // Flush one cycle after three requests
    req(12'd1, 1'b1); req(12'd2, 1'b1); req(12'd3, 1'b1);
    saw_valid = 1'b0;
    step(1'b1, 1'b1, 1'b0, 12'h0, 32'h0, 1'b1, 12'd4, 1'b1);
    chk("flush_ready", {31'b0, obs_ready}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      idle(1'b1);
      if (obs_valid) saw_valid = 1'b1;
      if (i == 0) chk("flush_busy", {31'b0, obs_busy}, 32'd0);
    end
    chk("flush_no_resp", {31'b0, saw_valid}, 32'd0);
    req(12'd6, 1'b1);
    drain();

    // Load collides with a request
    step(1'b1, 1'b0, 1'b1, 12'd5, 32'hDEAD, 1'b1, 12'd5, 1'b1);
    chk("load_blocks_req", {31'b0, obs_ready}, 32'd0);
    req(12'd5, 1'b1);
    for (int i = 0; i < 3; i++) idle(1'b1);
    chk("load_readback", obs_data, 32'hDEAD);
    drain();

    // Reset with two responses buffered
    req(12'd0, 1'b0); req(12'd1, 1'b0);
    for (int i = 0; i < 3; i++) idle(1'b0);
    chk("pre_rst_buffered", {31'b0, obs_valid}, 32'd1);
    step(1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 1'b1, 12'd2, 1'b1);
    step(1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 12'h0, 1'b1);
    chk("mid_rst_valid", {31'b0, obs_valid}, 32'd0);
    chk("mid_rst_busy", {31'b0, obs_busy}, 32'd0);
    chk("mid_rst_ready", {31'b0, obs_ready}, 32'd0);
    chk("mid_rst_data", obs_data, 32'd0);
    req(12'd0, 1'b1);
    drain();

    // Top address
    req(12'hFFF, 1'b1);
    for (int i = 0; i < 3; i++) idle(1'b1);
    chk("top_data", obs_data, 32'h1234_5678);
    chk("top_addr", {20'b0, obs_addr}, 32'hFFF);
    drain();

    // Random traffic against the model
    for (int i = 0; i < 2000; i++) begin
      logic        r_rst, r_fl, r_ld, r_rv, r_rr;
      logic [11:0] r_a, r_la;
      r_rst = ($urandom_range(0, 127) != 0);
      r_fl  = ($urandom_range(0, 31) == 0);
      r_ld  = ($urandom_range(0, 15) == 0);
      r_rv  = ($urandom_range(0, 3) != 0);
      r_rr  = ($urandom_range(0, 2) != 0);
      r_a   = ($urandom_range(0, 9) == 0) ? 12'hFFF : 12'($urandom_range(0, 15));
      r_la  = 12'($urandom_range(0, 15));
      step(r_rst, r_fl, r_ld, r_la, $urandom, r_rv, r_a, r_rr);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
